// File: rtl/dram_arb_pkg.sv
// ----------------------------------------------------------------------------
// ram_op_enum -- shared definitions for the DRAM arbiter slice.
//
// Contents:
//   DRAM_WR_B / DRAM_WR_H / DRAM_WR_W : access size codes carried on
//                                       mn_wr_sel_i (byte, halfword, word)
//   dram_state_e                      : arbiter FSM state encoding
// ----------------------------------------------------------------------------
package ram_op_enum;

   localparam logic [2:0] DRAM_WR_B = 3'b000;
   localparam logic [2:0] DRAM_WR_H = 3'b001;
   localparam logic [2:0] DRAM_WR_W = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } dram_state_e;

endpackage

// File: rtl/dram_lane_ctl.sv
// ----------------------------------------------------------------------------
// dram_lane_ctl -- combinational byte-lane control for one RAM access.
//
// Ports:
//   wr_sel     in  3     access size code (DRAM_WR_B/H/W, others undefined)
//   addr_lo    in  2     low byte-address bits of the access
//   wr_data    in  XLEN  right-aligned store data
//   byte_en    out 4     byte-lane enables for the size/offset
//   lane_data  out XLEN  store data replicated across all lanes
//   misaligned out 1     access cannot be issued (bad alignment or size code)
// ----------------------------------------------------------------------------
module dram_lane_ctl
   import ram_op_enum::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      wr_sel,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] wr_data,
   output logic [3:0]      byte_en,
   output logic [XLEN-1:0] lane_data,
   output logic            misaligned
);

   // Undefined size codes fall through the default and are flagged as
   // misaligned, so the arbiter refuses them like a bad alignment.
   always_comb begin
      byte_en    = 4'b0000;
      lane_data  = wr_data;
      misaligned = 1'b1;
      case (wr_sel)
         DRAM_WR_B: begin
            byte_en    = 4'b0001 << addr_lo;
            lane_data  = {(XLEN/8){wr_data[7:0]}};
            misaligned = 1'b0;
         end
         DRAM_WR_H: begin
            byte_en    = 4'b0011 << {addr_lo[1], 1'b0};
            lane_data  = {(XLEN/16){wr_data[15:0]}};
            misaligned = addr_lo[0];
         end
         DRAM_WR_W: begin
            byte_en    = 4'b1111;
            lane_data  = wr_data;
            misaligned = (addr_lo != 2'b00);
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/dram_arb.sv
// ----------------------------------------------------------------------------
// dram_arb -- two-requester arbiter in front of a single-port word RAM.
//
// Build option:
//   DRAM_ARB_RR_EN  defined   : round-robin between m0 and m1
//                   undefined : fixed priority, m0 always wins
//
// Ports (n = 0,1):
//   clk_i, rst_n_i           clock, async active-low reset
//   mn_req_i                 request, held until mn_gnt_o
//   mn_wr_en_i               1 = store, 0 = load
//   mn_wr_sel_i [2:0]        size code B/H/W
//   mn_addr_i   [XLEN-1:0]   byte address
//   mn_wr_data_i[XLEN-1:0]   right-aligned store data
//   mn_gnt_o                 pulse when the access is issued
//   mn_rd_valid_o            pulse when load data is on mn_rd_data_o
//   mn_rd_data_o[XLEN-1:0]   full aligned RAM word
//   mn_err_o                 pulse on a refused (misaligned) access
//   ram_addr_o  [XLEN-1:0]   word address (byte address with [1:0] = 0)
//   ram_rd_en_o              read strobe
//   ram_wr_byte_en_o[3:0]    byte-lane write enables
//   ram_wr_data_o[XLEN-1:0]  lane-replicated store data
//   ram_rd_data_i[XLEN-1:0]  read data, one cycle after ram_rd_en_o
// ----------------------------------------------------------------------------
module dram_arb
   import ram_op_enum::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            m0_req_i,
   input  logic            m0_wr_en_i,
   input  logic [2:0]      m0_wr_sel_i,
   input  logic [XLEN-1:0] m0_addr_i,
   input  logic [XLEN-1:0] m0_wr_data_i,
   output logic            m0_gnt_o,
   output logic            m0_rd_valid_o,
   output logic [XLEN-1:0] m0_rd_data_o,
   output logic            m0_err_o,
   input  logic            m1_req_i,
   input  logic            m1_wr_en_i,
   input  logic [2:0]      m1_wr_sel_i,
   input  logic [XLEN-1:0] m1_addr_i,
   input  logic [XLEN-1:0] m1_wr_data_i,
   output logic            m1_gnt_o,
   output logic            m1_rd_valid_o,
   output logic [XLEN-1:0] m1_rd_data_o,
   output logic            m1_err_o,
   output logic [XLEN-1:0] ram_addr_o,
   output logic            ram_rd_en_o,
   output logic [3:0]      ram_wr_byte_en_o,
   output logic [XLEN-1:0] ram_wr_data_o,
   input  logic [XLEN-1:0] ram_rd_data_i
);

   dram_state_e     state;
   logic            win;
   logic            r_wr_en;
   logic [2:0]      r_sel;
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_data;
   logic            pick_m1;
   logic [3:0]      lane_byte_en;
   logic [XLEN-1:0] lane_data;
   logic            misaligned;
   logic            in_access;
   logic            in_resp;

`ifdef DRAM_ARB_RR_EN
   // rr_ptr names the requester preferred on the next simultaneous request;
   // it flips away from whoever was granted, so ties alternate.
   logic rr_ptr;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rr_ptr <= 1'b0;
      end else if (state == ST_IDLE && (m0_req_i || m1_req_i)) begin
         rr_ptr <= ~pick_m1;
      end
   end

   always_comb begin
      pick_m1 = m1_req_i;
      if (m0_req_i && m1_req_i) begin
         pick_m1 = rr_ptr;
      end
   end
`else
   // Fixed priority: m1 only wins when m0 is not asking.
   always_comb begin
      pick_m1 = m1_req_i && !m0_req_i;
   end
`endif

   // The winner's request is captured in IDLE; everything driven during
   // ACCESS and RESP comes from these registers, so requesters may change
   // their inputs as soon as they see the grant.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state   <= ST_IDLE;
         win     <= 1'b0;
         r_wr_en <= 1'b0;
         r_sel   <= 3'b000;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (m0_req_i || m1_req_i) begin
                  win     <= pick_m1;
                  r_wr_en <= pick_m1 ? m1_wr_en_i   : m0_wr_en_i;
                  r_sel   <= pick_m1 ? m1_wr_sel_i  : m0_wr_sel_i;
                  r_addr  <= pick_m1 ? m1_addr_i    : m0_addr_i;
                  r_data  <= pick_m1 ? m1_wr_data_i : m0_wr_data_i;
                  state   <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               state <= (r_wr_en || misaligned) ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   dram_lane_ctl #(.XLEN(XLEN)) u_lane (
      .wr_sel     (r_sel),
      .addr_lo    (r_addr[1:0]),
      .wr_data    (r_data),
      .byte_en    (lane_byte_en),
      .lane_data  (lane_data),
      .misaligned (misaligned)
   );

   assign in_access = (state == ST_ACCESS);
   assign in_resp   = (state == ST_RESP);

   // Refused accesses still grant so the requester releases its request,
   // but they carry no RAM strobe and never reach RESP.
   assign m0_gnt_o      = in_access && !win;
   assign m1_gnt_o      = in_access &&  win;
   assign m0_err_o      = in_access && !win && misaligned;
   assign m1_err_o      = in_access &&  win && misaligned;
   assign m0_rd_valid_o = in_resp && !win;
   assign m1_rd_valid_o = in_resp &&  win;
   assign m0_rd_data_o  = (in_resp && !win) ? ram_rd_data_i : '0;
   assign m1_rd_data_o  = (in_resp &&  win) ? ram_rd_data_i : '0;

   assign ram_addr_o       = {r_addr[XLEN-1:2], 2'b00};
   assign ram_rd_en_o      = in_access && !r_wr_en && !misaligned;
   assign ram_wr_byte_en_o = (in_access && r_wr_en && !misaligned) ? lane_byte_en : 4'b0000;
   assign ram_wr_data_o    = lane_data;

endmodule
